lc3_memaccess_fsm: RTL
======================

LC3_MEMACCESS_FSM -- requirements
Module: lc3_memaccess_fsm

Interface
REQ-001 Parameter TIMEOUT_CYC, default 16: maximum cycles one dmem request waits for dmem_ack before it is aborted.
REQ-002 clock  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 ex_valid  input  1  execute stage presents a memory operation.
REQ-005 ex_ready  output  1  block accepts a memory operation.
REQ-006 ex_op  input  2  00 LD/LDR, 01 ST/STR, 10 LDI, 11 STI.
REQ-007 ex_addr  input  16  effective address computed by execute.
REQ-008 ex_data  input  16  store data.
REQ-009 dmem_req, dmem_we  output  1 each  memory request and write enable.
REQ-010 dmem_addr, dmem_wdata  output  16 each  memory address and write data.
REQ-011 dmem_ack  input  1  memory completes the current request this cycle.
REQ-012 dmem_rdata  input  16  read data, valid when dmem_ack=1 and dmem_we=0.
REQ-013 wb_valid  output  1  result presented to writeback.
REQ-014 wb_ready  input  1  writeback accepts the result.
REQ-015 wb_data  output  16  loaded value (LD/LDI), otherwise 0.
REQ-016 wb_is_load, wb_err  output  1 each  result is a register load; access timed out.

Function
REQ-017 FSM states SHALL be IDLE, IND_RD, DATA_RD, DATA_WR and RESP.
REQ-018 ex_ready SHALL be 1 only in IDLE; ex_addr, ex_data and ex_op SHALL be captured on the cycle ex_valid&ex_ready=1.
REQ-019 On capture, IDLE SHALL go to DATA_RD for LD, DATA_WR for ST, and IND_RD for LDI/STI.
REQ-020 dmem_req SHALL be 1 in IND_RD, DATA_RD and DATA_WR, and 0 elsewhere.
REQ-021 dmem_addr, dmem_we and dmem_wdata SHALL be held stable until dmem_ack.
REQ-022 IND_RD SHALL read the captured address; on ack, dmem_rdata SHALL become the new address, and the FSM SHALL go to DATA_RD (LDI) or DATA_WR (STI).
REQ-023 DATA_RD on ack SHALL register dmem_rdata into wb_data, set wb_is_load=1, and go to RESP.
REQ-024 DATA_WR SHALL drive dmem_we=1 and dmem_wdata=captured ex_data; on ack it SHALL set wb_data=0 and wb_is_load=0, and go to RESP.
REQ-025 dmem_ack SHALL be honoured in the first request cycle, giving minimum accept-to-wb_valid latency of 2 cycles for LD/ST and 3 for LDI/STI.
REQ-026 A wait counter SHALL clear on entry to each request state and increment every request cycle without ack.
REQ-027 When the wait counter reaches TIMEOUT_CYC-1 without ack, the FSM SHALL go to RESP with wb_err=1, wb_data=0 and wb_is_load=0, and SHALL drop dmem_req the next cycle.
REQ-028 An ack on the timeout cycle SHALL win: normal completion, wb_err=0.
REQ-029 RESP SHALL hold wb_valid=1 and wb_data, wb_is_load and wb_err stable until wb_ready=1, then go to IDLE.
REQ-030 wb_ready SHALL be ignored outside RESP, and dmem_ack SHALL be ignored outside request states.
REQ-031 Back-to-back operations SHALL need one IDLE cycle between RESP and the next capture (no bypass).

Reset
REQ-032 Reset assertion SHALL force IDLE immediately, mid-operation included, with all outputs 0 except ex_ready=1, and registers and wait counter 0.
REQ-033 After reset deassertion, the first capture SHALL occur no earlier than the first rising edge with reset high.

Structure
REQ-034 A shared package SHALL hold the ex_op encoding enum, the FSM state enum and the 16-bit LC3 word typedef.
REQ-035 The wait counter SHALL be a sub-module, lc3_access_timer (clear, enable, expire output).

Verification
REQ-036 LD to 0x3000, dmem_rdata=0x1234 with ack in the first cycle -> wb_valid 2 cycles after accept, wb_data=0x1234, wb_is_load=1.
REQ-037 STI to 0x3010, pointer read returns 0x4000 -> second request addr=0x4000, we=1, wdata=ex_data=0xBEEF; wb_is_load=0.
REQ-038 LDI to 0x3020, ack delayed 3 cycles per access -> addr and wdata stable while waiting, and wb_data equals the final rdata.
REQ-039 LD with no ack, TIMEOUT_CYC=16 -> after 16 request cycles, wb_err=1, wb_data=0, and dmem_req drops.
REQ-040 wb_ready held 0 for 5 cycles in RESP -> wb_valid and wb_data stay stable and ex_ready stays 0.
REQ-041 Reset asserted in the DATA_WR wait cycle -> dmem_req=0 immediately and ex_ready=1, and no wb_valid after release.

Source files
------------

// File: rtl/lc3_memaccess_fsm_pkg.sv
// Shared types for the LC-3 memory-access stage: word type, ex_op encoding and FSM states.
package lc3_memaccess_fsm_pkg;

  localparam int unsigned LC3_WORD_W = 16;

  typedef logic [LC3_WORD_W-1:0] lc3_word_t;

  typedef enum logic [1:0] {
    OP_LD  = 2'b00,
    OP_ST  = 2'b01,
    OP_LDI = 2'b10,
    OP_STI = 2'b11
  } ex_op_e;

  typedef enum logic [2:0] {
    IDLE,
    IND_RD,
    DATA_RD,
    DATA_WR,
    RESP
  } mem_state_e;

  function automatic logic op_is_store(input ex_op_e op);
    return (op == OP_ST) || (op == OP_STI);
  endfunction

endpackage

// File: rtl/lc3_memaccess_fsm_if.sv
// Execute-side, data-memory and writeback signals of the memory-access stage.
interface lc3_memaccess_fsm_if;
  import lc3_memaccess_fsm_pkg::*;

  logic      ex_valid;
  logic      ex_ready;
  ex_op_e    ex_op;
  lc3_word_t ex_addr;
  lc3_word_t ex_data;

  logic      dmem_req;
  logic      dmem_we;
  lc3_word_t dmem_addr;
  lc3_word_t dmem_wdata;
  logic      dmem_ack;
  lc3_word_t dmem_rdata;

  logic      wb_valid;
  logic      wb_ready;
  lc3_word_t wb_data;
  logic      wb_is_load;
  logic      wb_err;

  modport slave (
    input  ex_valid, ex_op, ex_addr, ex_data, dmem_ack, dmem_rdata, wb_ready,
    output ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_data, wb_is_load, wb_err
  );

  modport master (
    output ex_valid, ex_op, ex_addr, ex_data, dmem_ack, dmem_rdata, wb_ready,
    input  ex_ready, dmem_req, dmem_we, dmem_addr, dmem_wdata,
           wb_valid, wb_data, wb_is_load, wb_err
  );

endinterface

// File: rtl/lc3_access_timer.sv
// Per-request wait counter; expire is high once TIMEOUT_CYC-1 unacknowledged cycles have elapsed.
module lc3_access_timer #(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int unsigned CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count;

  // Saturates at the expiry value so a stale count can never wrap back.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/lc3_memaccess_fsm.sv
// LC-3 memory-access stage: LD/ST/LDI/STI sequencing against a request/ack data memory.
module lc3_memaccess_fsm
  import lc3_memaccess_fsm_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic               clock,
  input  logic               reset,
  lc3_memaccess_fsm_if.slave bus
);

  mem_state_e state;
  ex_op_e     op_q;
  lc3_word_t  data_q;

  logic in_req;
  logic timer_clear;
  logic timer_enable;
  logic timer_expire;

  assign in_req = (state == IND_RD) || (state == DATA_RD) || (state == DATA_WR);

  always_comb begin
    timer_clear = 1'b0;
    if ((state == IDLE) && bus.ex_valid) timer_clear = 1'b1;
    if ((state == IND_RD) && bus.dmem_ack) timer_clear = 1'b1;
  end

  assign timer_enable = in_req && !bus.dmem_ack;

  lc3_access_timer #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_enable),
    .expire (timer_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state          <= IDLE;
      op_q           <= OP_LD;
      data_q         <= '0;
      bus.ex_ready   <= 1'b1;
      bus.dmem_req   <= 1'b0;
      bus.dmem_we    <= 1'b0;
      bus.dmem_addr  <= '0;
      bus.dmem_wdata <= '0;
      bus.wb_valid   <= 1'b0;
      bus.wb_data    <= '0;
      bus.wb_is_load <= 1'b0;
      bus.wb_err     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.ex_valid) begin
            op_q          <= bus.ex_op;
            data_q        <= bus.ex_data;
            bus.ex_ready  <= 1'b0;
            bus.dmem_req  <= 1'b1;
            bus.dmem_addr <= bus.ex_addr;
            unique case (bus.ex_op)
              OP_LD: state <= DATA_RD;
              OP_ST: begin
                state          <= DATA_WR;
                bus.dmem_we    <= 1'b1;
                bus.dmem_wdata <= bus.ex_data;
              end
              default: state <= IND_RD;
            endcase
          end
        end

        IND_RD, DATA_RD, DATA_WR: begin
          if (bus.dmem_ack) begin
            if (state == IND_RD) begin
              // Pointer read done: the returned word becomes the data address.
              bus.dmem_addr <= bus.dmem_rdata;
              if (op_is_store(op_q)) begin
                state          <= DATA_WR;
                bus.dmem_we    <= 1'b1;
                bus.dmem_wdata <= data_q;
              end else begin
                state <= DATA_RD;
              end
            end else begin
              state          <= RESP;
              bus.dmem_req   <= 1'b0;
              bus.dmem_we    <= 1'b0;
              bus.dmem_addr  <= '0;
              bus.dmem_wdata <= '0;
              bus.wb_valid   <= 1'b1;
              bus.wb_err     <= 1'b0;
              bus.wb_is_load <= (state == DATA_RD);
              bus.wb_data    <= (state == DATA_RD) ? bus.dmem_rdata : '0;
            end
          end else if (timer_expire) begin
            state          <= RESP;
            bus.dmem_req   <= 1'b0;
            bus.dmem_we    <= 1'b0;
            bus.dmem_addr  <= '0;
            bus.dmem_wdata <= '0;
            bus.wb_valid   <= 1'b1;
            bus.wb_err     <= 1'b1;
            bus.wb_is_load <= 1'b0;
            bus.wb_data    <= '0;
          end
        end

        RESP: begin
          if (bus.wb_ready) begin
            state          <= IDLE;
            bus.ex_ready   <= 1'b1;
            bus.wb_valid   <= 1'b0;
            bus.wb_data    <= '0;
            bus.wb_is_load <= 1'b0;
            bus.wb_err     <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          bus.ex_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
